mem_access_stage: RTL
=====================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter PAYLOAD_W, default 64: width of the opaque pipeline payload (control bits, rdist, pc fields) carried through the stage.
REQ-002 Parameter ADDR_W, default 32: data-memory address width.
REQ-003 Parameter TIMEOUT, default 255: maximum MEM-state cycles before forced completion; 0 disables the timeout.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers an instruction.
REQ-007 in_ready  output  1  stage accepts the offer this cycle.
REQ-008 in_mem_read  input  1  instruction is a load.
REQ-009 in_mem_write  input  1  instruction is a store.
REQ-010 in_addr  input  ADDR_W  ALU result / effective address.
REQ-011 in_wdata  input  32  store data.
REQ-012 in_payload  input  PAYLOAD_W  pass-through pipeline payload.
REQ-013 out_valid  output  1  output slot holds a completed instruction.
REQ-014 out_ready  input  1  downstream consumes the slot this cycle.
REQ-015 out_payload  output  PAYLOAD_W  payload of the completed instruction.
REQ-016 out_alu_result  output  ADDR_W  in_addr of the completed instruction.
REQ-017 out_read_data  output  32  load data; 0 for non-loads.
REQ-018 out_err  output  1  completion was forced by timeout.
REQ-019 mem_req  output  1  request to data memory, held until mem_ack.
REQ-020 mem_we  output  1  request is a write.
REQ-021 mem_addr  output  ADDR_W  request address.
REQ-022 mem_wdata  output  32  request write data.
REQ-023 mem_ack  input  1  memory completes the request this cycle.
REQ-024 mem_rdata  input  32  read data, valid in the mem_ack cycle.

Function
REQ-025 The FSM SHALL have states IDLE and MEM; a one-entry output slot (out_valid plus data) SHALL be held independently of the FSM.
REQ-026 in_ready SHALL equal (state==IDLE) AND (NOT out_valid OR out_ready), combinationally.
REQ-027 Accept = in_valid AND in_ready; a non-memory instruction (both mem flags 0) SHALL appear in the slot the next cycle: latency 1, out_read_data=0, out_err=0.
REQ-028 An accepted load or store SHALL latch address, data, payload and type, enter MEM, and drive mem_req=1 with mem_we/mem_addr/mem_wdata stable from the next cycle until the mem_ack cycle inclusive.
REQ-029 If in_mem_read and in_mem_write are both 1, the instruction SHALL be treated as a store.
REQ-030 On mem_ack in MEM, the slot SHALL load the latched payload/address, out_read_data=mem_rdata for loads or 0 for stores, out_err=0; state SHALL return to IDLE; mem_req SHALL deassert the following cycle.
REQ-031 A wait counter SHALL clear on entering MEM and increment each MEM cycle without mem_ack; when TIMEOUT!=0 and the counter reaches TIMEOUT, the stage SHALL complete with out_read_data=32'hDEADBEEF, out_err=1, drop mem_req, and return to IDLE.
REQ-032 mem_ack arriving in the timeout cycle SHALL take priority (normal completion); mem_ack outside MEM SHALL be ignored.
REQ-033 The slot SHALL hold all contents unchanged while out_valid=1 and out_ready=0; out_valid SHALL clear after out_ready=1 unless refilled the same cycle.
REQ-034 Throughput SHALL be one non-memory instruction per cycle with out_ready held 1; a memory instruction SHALL occupy the stage from accept through its completion cycle.
REQ-035 The slot SHALL be empty or draining whenever a memory instruction completes; no completion is ever lost or overwritten.

Reset
REQ-036 While reset=1, regardless of CLK: state=IDLE, counter=0, out_valid=0, out_err=0, mem_req=0, mem_we=0, and all data outputs 0.
REQ-037 Reset asserted mid-MEM SHALL abandon the request (mem_req=0 immediately); no completion is produced after release.
REQ-038 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-039 Non-memory op, payload 64'h1234, out_ready=1 -> out_valid=1 next cycle with out_payload=64'h1234, out_read_data=0.
REQ-040 Load to 0x40, mem_ack three cycles after mem_req with mem_rdata=0xCAFEF00D -> out_read_data=0xCAFEF00D, in_ready=0 throughout MEM.
REQ-041 Store, out_ready=0 for 5 cycles after completion -> slot stable, in_ready=0, one transfer when out_ready rises.
REQ-042 TIMEOUT=4, load with no mem_ack -> after 4 MEM cycles out_err=1, out_read_data=0xDEADBEEF, mem_req=0.
REQ-043 Reset pulsed while mem_req=1 -> mem_req and out_valid 0 at once, late mem_ack ignored, in_ready=1 after release.
REQ-044 Back-to-back ops: ALU, load, ALU with out_ready=1 -> three completions in order, the load's payload between the two ALU payloads.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: ALU ops pass straight to a one-entry output slot,
// loads/stores hold a data-memory request until ack or timeout.
module mem_access_stage #(
  parameter int PAYLOAD_W = 64,
  parameter int ADDR_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mem_read,
  input  logic                 in_mem_write,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [31:0]          in_wdata,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [ADDR_W-1:0]    out_alu_result,
  output logic [31:0]          out_read_data,
  output logic                 out_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ack,
  input  logic [31:0]          mem_rdata
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic {IDLE, MEM} state_t;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic                 is_load;
  } lat_t;

  state_t        state;
  lat_t          lat;
  logic [CW-1:0] cnt;
  logic          accept, is_mem, ack_hit, to_hit;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_mem_read || in_mem_write;
  assign ack_hit  = (state == MEM) && mem_ack;
  // Timeout fires on the MEM cycle that would push the counter to TIMEOUT; ack wins.
  assign to_hit   = TO_EN && (state == MEM) && !mem_ack && (cnt == TO_LAST);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (accept && is_mem) begin
          state       <= MEM;
          cnt         <= '0;
          mem_req     <= 1'b1;
          mem_we      <= in_mem_write;
          mem_addr    <= in_addr;
          mem_wdata   <= in_wdata;
          lat.payload <= in_payload;
          lat.is_load <= in_mem_read && !in_mem_write;
        end
        MEM: if (ack_hit || to_hit) begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output slot: only filled when empty or draining, so no completion is overwritten.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_payload    <= '0;
      out_alu_result <= '0;
      out_read_data  <= '0;
      out_err        <= 1'b0;
    end else if (accept && !is_mem) begin
      out_valid      <= 1'b1;
      out_payload    <= in_payload;
      out_alu_result <= in_addr;
      out_read_data  <= '0;
      out_err        <= 1'b0;
    end else if (ack_hit) begin
      out_valid      <= 1'b1;
      out_payload    <= lat.payload;
      out_alu_result <= mem_addr;
      out_read_data  <= lat.is_load ? mem_rdata : 32'h0;
      out_err        <= 1'b0;
    end else if (to_hit) begin
      out_valid      <= 1'b1;
      out_payload    <= lat.payload;
      out_alu_result <= mem_addr;
      out_read_data  <= 32'hDEADBEEF;
      out_err        <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
